// File: rtl/jk_cmd_pkg.sv
// jk_cmd_pkg: shared op/state encodings for the JK latch command driver
package jk_cmd_pkg;
  localparam int OP_W = 3;
  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_SET    = 3'd1,
    OP_CLR    = 3'd2,
    OP_TOGGLE = 3'd3,
    OP_LOAD   = 3'd4
  } op_e;
  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    SETTLE,
    CHECK
  } state_e;
  function automatic logic op_illegal(input logic [OP_W-1:0] op);
    return op > OP_LOAD;
  endfunction
endpackage

// File: rtl/jk_cmd_decode.sv
// jk_cmd_decode: maps op/mask/data/shadow to latch J/K and the post-command shadow
module jk_cmd_decode
  import jk_cmd_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic [OP_W-1:0] op,
  input  logic [SIZE-1:0] mask,
  input  logic [SIZE-1:0] data,
  input  logic [SIZE-1:0] shadow,
  output logic [SIZE-1:0] j,
  output logic [SIZE-1:0] k,
  output logic [SIZE-1:0] nxt
);
  // TOGGLE splits by current value so a bit never sees J=K=1 on a level latch
  always_comb begin
    j = op == OP_SET    ? mask :
        op == OP_TOGGLE ? mask & ~shadow :
        op == OP_LOAD   ? mask & data : '0;
    k = op == OP_CLR    ? mask :
        op == OP_TOGGLE ? mask & shadow :
        op == OP_LOAD   ? mask & ~data : '0;
    nxt = (shadow & ~(j | k)) | j;
  end
endmodule

// File: rtl/jk_cmd_driver.sv
// jk_cmd_driver: turns SET/CLR/TOGGLE/LOAD commands into one-cycle JK latch windows and checks readback
module jk_cmd_driver
  import jk_cmd_pkg::*;
#(
  parameter int SIZE = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            cmd_valid,
  output logic            cmd_ready,
  input  logic [OP_W-1:0] cmd_op,
  input  logic [SIZE-1:0] cmd_mask,
  input  logic [SIZE-1:0] cmd_data,
  output logic [SIZE-1:0] J,
  output logic [SIZE-1:0] K,
  output logic            latch_en,
  input  logic [SIZE-1:0] q_in,
  output logic [SIZE-1:0] shadow,
  output logic            done,
  output logic            mismatch,
  output logic            illegal,
  input  logic            clr_err
);
  state_e          state, state_n;
  logic [OP_W-1:0] op_r;
  logic [SIZE-1:0] mask_r, data_r, dec_j, dec_k, dec_nxt;
  logic            accept;
  jk_cmd_decode #(.SIZE(SIZE)) u_decode (
    .op(op_r),
    .mask(mask_r),
    .data(data_r),
    .shadow(shadow),
    .j(dec_j),
    .k(dec_k),
    .nxt(dec_nxt)
  );
  assign accept = cmd_valid && state == IDLE;
  always_comb begin
    state_n = state;
    state_n = state == IDLE   ? (cmd_valid ? DRIVE : IDLE) :
              state == DRIVE  ? SETTLE :
              state == SETTLE ? CHECK : IDLE;
  end
  // Shadow is stable from accept to end of DRIVE, so decoding from registers is glitch-free
  always_comb begin
    cmd_ready = state == IDLE;
    latch_en  = state == DRIVE;
    J         = state == DRIVE ? dec_j : '0;
    K         = state == DRIVE ? dec_k : '0;
    done      = state == CHECK;
    illegal   = state == CHECK && op_illegal(op_r);
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      shadow   <= '0;
      mismatch <= 1'b0;
    end else begin
      state <= state_n;
      if (state == DRIVE) shadow <= dec_nxt;
      if (state == CHECK && q_in != shadow) mismatch <= 1'b1;
      else if (clr_err) mismatch <= 1'b0;
    end
  end
  always_ff @(posedge clk) begin
    if (accept) begin
      op_r   <= cmd_op;
      mask_r <= cmd_mask;
      data_r <= cmd_data;
    end
  end
endmodule

// File: tb/tb_jk_cmd_driver.sv
// tb_jk_cmd_driver: directed scoreboard bench for jk_cmd_driver with a JK latch bank model
module tb_jk_cmd_driver;
  logic       clk, reset, cmd_valid, cmd_ready, latch_en, done, mismatch, illegal, clr_err;
  logic [2:0] cmd_op;
  logic [7:0] cmd_mask, cmd_data, J, K, q_in, shadow, q_lat, fault;
  typedef struct packed {
    logic [7:0] j;
    logic [7:0] k;
    logic [7:0] sh;
    logic       ill;
  } exp_t;
  exp_t       sb[$];
  int         checks = 0, failures = 0, ph = 0, done_cnt = 0, ill_cnt = 0, low_cnt = 0;
  logic [7:0] msh = '0;
  logic       mm = 1'b0;

  jk_cmd_driver #(.SIZE(8)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_mask(cmd_mask), .cmd_data(cmd_data), .J(J), .K(K),
    .latch_en(latch_en), .q_in(q_in), .shadow(shadow), .done(done),
    .mismatch(mismatch), .illegal(illegal), .clr_err(clr_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Level latch bank: transparent for the whole DRIVE cycle, so it settles at that cycle's closing edge
  always @(posedge clk) begin
    if (reset) q_lat <= '0;
    else if (latch_en) q_lat <= (q_lat & ~K) | J;
  end
  assign q_in = q_lat ^ fault;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t predict(input logic [2:0] op, input logic [7:0] m, d, s);
    exp_t e;
    e = '0;
    e.sh = s;
    e.ill = op > 3'd4;
    case (op)
      3'd1: begin e.j = m; e.sh = s | m; end
      3'd2: begin e.k = m; e.sh = s & ~m; end
      3'd3: begin e.j = m & ~s; e.k = m & s; e.sh = s ^ m; end
      3'd4: begin e.j = m & d; e.k = m & ~d; e.sh = (s & ~m) | (d & m); end
      default: ;
    endcase
    return e;
  endfunction

  task automatic mon();
    exp_t cur;
    cur = sb.size() > 0 ? sb[0] : '0;
    chk("cmd_ready", cmd_ready, ph == 0);
    chk("latch_en", latch_en, ph == 1);
    chk("J", J, ph == 1 ? cur.j : 8'h00);
    chk("K", K, ph == 1 ? cur.k : 8'h00);
    chk("done", done, ph == 3);
    chk("illegal", illegal, ph == 3 && cur.ill);
    chk("shadow", shadow, msh);
    chk("qbank", q_lat, msh);
    chk("mismatch", mismatch, mm);
    if (done) done_cnt++;
    if (illegal) ill_cnt++;
    if (!cmd_ready) low_cnt++;
  endtask

  // Predict the effect of the coming edge from the inputs now applied, then observe after it
  task automatic tick();
    if (reset) begin
      ph = 0; msh = '0; mm = 1'b0;
      sb.delete();
    end else begin
      if (ph == 3 && fault != 0) mm = 1'b1;
      else if (clr_err) mm = 1'b0;
      if (ph == 1) msh = sb[0].sh;
      if (ph == 3) void'(sb.pop_front());
      if (ph == 0 && cmd_valid) begin
        sb.push_back(predict(cmd_op, cmd_mask, cmd_data, msh));
        ph = 1;
      end else if (ph != 0) ph = ph == 3 ? 0 : ph + 1;
    end
    @(negedge clk);
    mon();
  endtask

  task automatic issue(input logic [2:0] op, input logic [7:0] m, d, input logic flt, clr);
    cmd_valid = 1'b1; cmd_op = op; cmd_mask = m; cmd_data = d;
    tick();
    cmd_valid = 1'b0;
    tick();
    fault = {7'b0, flt};
    clr_err = clr;
    tick();
    tick();
    fault = '0;
    clr_err = 1'b0;
  endtask

  initial begin
    int d0, i0, l0;
    logic [2:0] bop[3] = '{3'd3, 3'd2, 3'd1};
    logic [7:0] bmask[3] = '{8'h11, 8'hC0, 8'h0A};
    reset = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_mask = '0; cmd_data = '0;
    clr_err = 1'b0; fault = '0;
    tick(); tick();
    reset = 1'b0;
    chk("rst_shadow", shadow, 8'h00);
    chk("rst_J", J, 8'h00);
    chk("rst_K", K, 8'h00);
    chk("rst_latch_en", latch_en, 1'b0);
    chk("rst_ready", cmd_ready, 1'b1);
    chk("rst_mismatch", mismatch, 1'b0);

    issue(3'd1, 8'h0F, 8'h00, 1'b0, 1'b0);
    chk("set_shadow", shadow, 8'h0F);
    issue(3'd3, 8'hFF, 8'h00, 1'b0, 1'b0);
    chk("toggle_shadow", shadow, 8'hF0);
    chk("toggle_q", q_in, 8'hF0);
    issue(3'd4, 8'h3C, 8'hA5, 1'b0, 1'b0);
    chk("load_shadow", shadow, 8'hE4);
    issue(3'd1, 8'h00, 8'h00, 1'b0, 1'b0);
    chk("mask0_shadow", shadow, 8'hE4);

    d0 = done_cnt; l0 = low_cnt;
    cmd_valid = 1'b1;
    for (int c = 0; c < 12; c++) begin
      if (ph == 0 && sb.size() == 0 && c / 4 < 3) begin
        cmd_op = bop[c / 4]; cmd_mask = bmask[c / 4]; cmd_data = '0;
      end
      tick();
    end
    cmd_valid = 1'b0;
    chk("b2b_done_pulses", done_cnt - d0, 3);
    chk("b2b_ready_low", low_cnt - l0, 9);
    chk("b2b_ready_back", cmd_ready, 1'b1);

    issue(3'd1, 8'h02, 8'h00, 1'b1, 1'b0);
    chk("fault_mismatch", mismatch, 1'b1);
    issue(3'd2, 8'h02, 8'h00, 1'b0, 1'b0);
    chk("fault_sticky", mismatch, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;
    chk("clr_err", mismatch, 1'b0);
    issue(3'd3, 8'h81, 8'h00, 1'b1, 1'b1);
    chk("set_beats_clr", mismatch, 1'b1);
    clr_err = 1'b1;
    tick();
    clr_err = 1'b0;

    d0 = done_cnt;
    cmd_valid = 1'b1; cmd_op = 3'd1; cmd_mask = 8'hFF;
    tick();
    cmd_valid = 1'b0;
    chk("pre_rst_latch_en", latch_en, 1'b1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("rst_drive_ready", cmd_ready, 1'b1);
    chk("rst_drive_shadow", shadow, 8'h00);
    chk("rst_drive_J", J, 8'h00);
    tick(); tick(); tick();
    chk("rst_drive_no_done", done_cnt - d0, 0);

    d0 = done_cnt; i0 = ill_cnt;
    issue(3'd6, 8'hFF, 8'h5A, 1'b0, 1'b0);
    chk("ill_done", done_cnt - d0, 1);
    chk("ill_pulse", ill_cnt - i0, 1);
    chk("ill_shadow", shadow, 8'h00);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
